// File: rtl/fetch_queue_unit.sv
// Fetch stage: owns the PC, issues sequential PC+4 reads to a 1-cycle imem and queues {pc, inst} for decode.
// Issue-to-valid latency 2 cycles; issue is credit-limited (queued + in-flight < QDEPTH), decode stalls via inst_ready.

module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push_vld,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop_rdy,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_rdy)  rd_ptr <= ptr_inc(rd_ptr);
      if (push_vld && !pop_rdy)
        count <= count + CW'(1);
      else if (!push_vld && pop_rdy)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld && !flush)
      mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

module fetch_queue_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              QDEPTH   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            halt,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] fetch_pc
);
  localparam int CW = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic            has_credit;
  logic            push_vld;
  logic            pop_rdy;
  fetch_entry_t    push_dat;
  fetch_entry_t    head_dat;

  // The in-flight read already owns a slot, so it counts against the queue.
  assign has_credit = (int'(count) + int'(inflight)) < QDEPTH;
  assign imem_en    = !reset && !redirect && !halt && has_credit;
  assign imem_addr  = pc;
  assign fetch_pc   = pc;

  assign push_vld   = inflight && !redirect;
  assign push_dat   = '{pc: inflight_pc, inst: imem_rdata};
  assign inst_valid = (count != '0) && !redirect;
  assign pop_rdy    = inst_valid && inst_ready;
  assign inst_pc    = head_dat.pc;
  assign inst_data  = head_dat.inst;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else if (redirect) begin
      pc       <= redirect_pc & ~XLEN'(3);
      inflight <= 1'b0;
    end else begin
      inflight <= imem_en;
      if (imem_en) begin
        pc          <= pc + XLEN'(4);
        inflight_pc <= pc;
      end
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (pop_rdy),
    .head_dat (head_dat),
    .count    (count)
  );
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios then random ready/halt/redirect/reset traffic,
// checked cycle by cycle against an occupancy/PC-stream reference model and a delivered-instruction scoreboard.

module tb_fetch_queue_unit;
  localparam int          XLEN     = 32;
  localparam int          QDEPTH   = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] fetch_pc;

  int tests;
  int fails;

  // Expected delivered PCs in order; refilled by stimulus, consumed by the monitor.
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc;

  // Reference model: slots owned (queued + in flight), whether a read was issued last cycle, next issue PC.
  int          outstanding;
  bit          issued_last;
  logic [31:0] exp_pc;

  fetch_queue_unit #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .QDEPTH   (QDEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .fetch_pc    (fetch_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1234_5678;
  endfunction

  // Synchronous instruction memory: data appears the cycle after the request.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 64) begin
      exp_q.push_back(gen_pc);
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] target);
    exp_q.delete();
    gen_pc = target;
    refill();
  endtask

  // One clock cycle of stimulus; outputs may be sampled on return (2 time units after the edge).
  task automatic cyc(input bit rdy, input bit hlt, input bit rd, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    inst_ready  = rdy;
    halt        = hlt;
    redirect    = rd;
    redirect_pc = rpc;
    if (rd) restart(rpc & 32'hFFFF_FFFC);
    else    refill();
    #1;
  endtask

  // Reset asserted mid-cycle; outputs must drop without waiting for a clock edge.
  task automatic do_reset(input int ncyc, input bit rdy);
    @(posedge clk);
    #3;
    reset = 1'b1;
    restart(RESET_PC);
    #1;
    chk("async_rst_imem_en", imem_en, 0);
    chk("async_rst_inst_valid", inst_valid, 0);
    chk("async_rst_fetch_pc", fetch_pc, RESET_PC);
    repeat (ncyc) @(posedge clk);
    #1;
    reset      = 1'b0;
    redirect   = 1'b0;
    halt       = 1'b0;
    inst_ready = rdy;
    #1;
  endtask

  always @(negedge clk) begin
    bit          exp_en;
    bit          exp_vld;
    bit          popped;
    logic [31:0] e;
    if (reset) begin
      chk("rst_imem_en", imem_en, 0);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_fetch_pc", fetch_pc, RESET_PC);
      chk("rst_imem_addr", imem_addr, RESET_PC);
      outstanding = 0;
      issued_last = 0;
      exp_pc      = RESET_PC;
    end else begin
      exp_en  = !halt && !redirect && (outstanding < QDEPTH);
      exp_vld = !redirect && ((outstanding - int'(issued_last)) > 0);
      popped  = exp_vld && inst_ready;
      chk("imem_en", imem_en, exp_en);
      chk("fetch_pc", fetch_pc, exp_pc);
      chk("imem_addr", imem_addr, exp_pc);
      chk("inst_valid", inst_valid, exp_vld);
      chk("count_bound", dut.u_fifo.count <= QDEPTH, 1);
      if (popped) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard_empty: got pop expected none at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc", inst_pc, e);
          chk("inst_data", inst_data, mem_word(e));
        end
      end
      if (redirect) begin
        outstanding = 0;
        issued_last = 0;
        exp_pc      = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        outstanding = outstanding + int'(exp_en) - int'(popped);
        issued_last = exp_en;
        if (exp_en) exp_pc = exp_pc + 32'd4;
      end
    end
  end

  initial begin
    int first;
    int n;
    tests       = 0;
    fails       = 0;
    outstanding = 0;
    issued_last = 0;
    exp_pc      = RESET_PC;
    reset       = 1'b1;
    halt        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    inst_ready  = 1'b0;
    restart(RESET_PC);

    // Streaming from reset: first valid two cycles after release.
    do_reset(3, 1'b1);
    first = -1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) cyc(1, 0, 0, 0);
      if (inst_valid && first < 0) first = k;
    end
    chk("first_valid_cycle", first, 2);

    // Decode stalled from reset: credit allows exactly QDEPTH issues, head held at RESET_PC.
    do_reset(2, 1'b0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) cyc(0, 0, 0, 0);
      if (imem_en) n++;
    end
    chk("stall_issue_count", n, QDEPTH);
    chk("stall_head_valid", inst_valid, 1);
    chk("stall_head_pc", inst_pc, RESET_PC);
    repeat (8) cyc(1, 0, 0, 0);

    // Redirect with a populated queue and a read in flight; low address bits ignored.
    cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 32'h0000_0103);
    chk("redir_valid_gated", inst_valid, 0);
    cyc(1, 0, 0, 0);
    chk("redir_issue_en", imem_en, 1);
    chk("redir_issue_addr", imem_addr, 32'h0000_0100);
    cyc(1, 0, 0, 0);
    chk("redir_r2_valid", inst_valid, 0);
    cyc(1, 0, 0, 0);
    chk("redir_r3_valid", inst_valid, 1);
    chk("redir_r3_pc", inst_pc, 32'h0000_0100);

    // Address wrap at the top of the space.
    cyc(1, 0, 1, 32'hFFFF_FFF8);
    cyc(1, 0, 0, 0);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    cyc(1, 0, 0, 0);
    chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0);
    chk("wrap_addr2", imem_addr, 32'h0000_0000);
    repeat (3) cyc(1, 0, 0, 0);

    // Halt right after an issue: pc holds, in-flight read still delivered, resume sequentially.
    cyc(1, 1, 0, 0);
    chk("halt_no_issue", imem_en, 0);
    chk("halt_pc", fetch_pc, 32'h0000_0010);
    repeat (3) cyc(1, 1, 0, 0);
    chk("halt_pc_held", fetch_pc, 32'h0000_0010);
    cyc(1, 0, 0, 0);
    chk("resume_en", imem_en, 1);
    chk("resume_addr", imem_addr, 32'h0000_0010);

    // Reset mid-stream with entries queued; sequence restarts at RESET_PC.
    repeat (4) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    do_reset(2, 1'b1);
    chk("post_rst_addr", imem_addr, RESET_PC);
    repeat (8) cyc(1, 0, 0, 0);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 5)
        do_reset(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
      else
        cyc($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 3, $urandom);
    end

    cyc(1, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
